// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch front end feeding the Issue unit.
// Holds the PC, issues one word-read request at a time to the memory
// controller, and pushes each returned instruction plus its address into
// Issue's FIFOs. A _clear pulse redirects the PC and drops any response
// still in flight.
//
// Build option: define FETCH_JAL_PREDICT_EN to follow JAL targets when
// computing the next PC. Without it the next PC is always pc + 4 and no
// opcode decode logic exists.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic [31:0] _clear_pc,
  input  logic        _issue_full,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  input  logic        _mem_ready,
  input  logic [31:0] _mem_data,
  output logic        _inst_ready_out,
  output logic [31:0] _inst_out,
  output logic [31:0] _inst_addr_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  // Registered state and outputs.
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_inst_ready;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;

  // Next-state values.
  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_mem_req_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic        w_inst_ready_nxt;
  logic [31:0] w_inst_nxt;
  logic [31:0] w_inst_addr_nxt;

  // Redirect target with the byte-offset bits cleared so the PC stays
  // word-aligned whatever the ROB hands us.
  logic [31:0] w_clear_pc;
  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;

  assign w_clear_pc = _clear_pc & WORD_MASK;
  assign w_seq_pc   = r_pc + 32'd4;

`ifdef FETCH_JAL_PREDICT_EN
  logic        w_is_jal;
  logic [31:0] w_jal_imm;
  logic [31:0] w_jal_target;

  // JAL immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} scattered
  // across the word, reassembled and sign-extended from bit 20.
  assign w_is_jal  = (_mem_data[6:0] == OP_JAL);
  assign w_jal_imm = {{11{_mem_data[31]}}, _mem_data[31], _mem_data[19:12],
                      _mem_data[20], _mem_data[30:21], 1'b0};
  // Targets are only 2-byte aligned in the ISA; the fetcher works in words,
  // so the target is truncated to a word address like any redirect.
  assign w_jal_target = (r_mem_addr + w_jal_imm) & WORD_MASK;
  assign w_next_pc    = w_is_jal ? w_jal_target : w_seq_pc;
`else
  assign w_next_pc = w_seq_pc;
`endif

  // Next-state decode for the fetch FSM; rdy_in low freezes everything
  // except the push strobe, which must never repeat.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_inst_ready_nxt = 1'b0;
    w_inst_nxt       = r_inst;
    w_inst_addr_nxt  = r_inst_addr;

    if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (_clear) begin
            w_pc_nxt = w_clear_pc;
          end else if (!_issue_full) begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_pc;
            w_state_nxt    = S_WAIT;
          end
        end

        S_WAIT: begin
          if (_clear) begin
            w_pc_nxt = w_clear_pc;
            if (_mem_ready) begin
              // Response lands with the flush: drop it, back to IDLE.
              w_mem_req_nxt = 1'b0;
              w_state_nxt   = S_IDLE;
            end else begin
              // Memory still owes us a word; keep the request stable and
              // swallow the answer when it arrives.
              w_state_nxt = S_DISCARD;
            end
          end else if (_mem_ready) begin
            w_inst_ready_nxt = 1'b1;
            w_inst_nxt       = _mem_data;
            w_inst_addr_nxt  = r_mem_addr;
            w_mem_req_nxt    = 1'b0;
            w_pc_nxt         = w_next_pc;
            w_state_nxt      = S_IDLE;
          end
        end

        S_DISCARD: begin
          if (_clear) begin
            w_pc_nxt = w_clear_pc;
          end
          if (_mem_ready) begin
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle.
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_inst_ready <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_addr  <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_inst_ready <= w_inst_ready_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_addr  <= w_inst_addr_nxt;
    end
  end

  assign _mem_req        = r_mem_req;
  assign _mem_addr       = r_mem_addr;
  assign _inst_ready_out = r_inst_ready;
  assign _inst_out       = r_inst;
  assign _inst_addr_out  = r_inst_addr;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher. Expected pushes are queued when the
// bench answers a request and popped whenever the DUT strobes _inst_ready_out.
module tb_inst_fetcher;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        _clear;
  logic [31:0] _clear_pc;
  logic        _issue_full;
  logic        _mem_req;
  logic [31:0] _mem_addr;
  logic        _mem_ready;
  logic [31:0] _mem_data;
  logic        _inst_ready_out;
  logic [31:0] _inst_out;
  logic [31:0] _inst_addr_out;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0080_006F;

  inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    ._clear         (_clear),
    ._clear_pc      (_clear_pc),
    ._issue_full    (_issue_full),
    ._mem_req       (_mem_req),
    ._mem_addr      (_mem_addr),
    ._mem_ready     (_mem_ready),
    ._mem_data      (_mem_data),
    ._inst_ready_out(_inst_ready_out),
    ._inst_out      (_inst_out),
    ._inst_addr_out (_inst_addr_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one clock and sample 1 ns after the edge; any push is scored.
  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (_inst_ready_out === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL push_unexpected: got addr=%h inst=%h, required no push",
                 _inst_addr_out, _inst_out);
      end else begin
        e = sb_q.pop_front();
        if (_inst_out !== e.data || _inst_addr_out !== e.addr) begin
          miscompares++;
          $display("FAIL push_value: got addr=%h inst=%h, required addr=%h inst=%h",
                   _inst_addr_out, _inst_out, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic do_reset(input logic full);
    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    _clear      = 1'b0;
    _clear_pc   = 32'h0;
    _issue_full = full;
    _mem_ready  = 1'b0;
    _mem_data   = 32'h0;
    tick();
    tick();
    rst_in = 1'b0;
    sb_q.delete();
  endtask

  // Wait (bounded) for a request and compare its address.
  task automatic expect_req(input logic [31:0] addr, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (_mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: no _mem_req within 20 cycles, required addr=%h", name, addr);
    end else if (_mem_addr !== addr) begin
      miscompares++;
      $display("FAIL %s: got _mem_addr=%h, required %h", name, _mem_addr, addr);
    end
  endtask

  // Answer the visible request 'lat' cycles after it rose.
  task automatic respond(input int lat, input logic [31:0] data, input bit push);
    for (int i = 0; i < lat - 1; i++) tick();
    _mem_ready = 1'b1;
    _mem_data  = data;
    if (push) sb_q.push_back({_mem_addr, data});
    tick();
    _mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++;
    if ({_mem_req, _mem_addr, _inst_ready_out, _inst_out, _inst_addr_out} !== 98'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b addr=%h rdy=%b inst=%h iaddr=%h, required all 0",
               _mem_req, _mem_addr, _inst_ready_out, _inst_out, _inst_addr_out);
    end
    // Reset mid-request must kill the request.
    expect_req(32'h0, "reset_pre_req");
    rst_in      = 1'b1;
    _issue_full = 1'b1;
    tick();
    rst_in = 1'b0;
    vectors++;
    if (_mem_req !== 1'b0 || _mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_req: got req=%b addr=%h, required req=0 addr=0",
               _mem_req, _mem_addr);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (_mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL full_hold cycle %0d: got _mem_req=%b, required 0", i, _mem_req);
      end
    end
    _issue_full = 1'b0;
    tick();
    vectors++;
    if (_mem_req !== 1'b1 || _mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL full_release: got req=%b addr=%h, required req=1 addr=0",
               _mem_req, _mem_addr);
    end
  endtask

  // Continues from the request at 0 left by test_backpressure.
  task automatic test_sequential();
    logic [31:0] addr;
    addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (_mem_req !== 1'b1 || _mem_addr !== addr) begin
        miscompares++;
        $display("FAIL seq_req %0d: got req=%b addr=%h, required req=1 addr=%h",
                 k, _mem_req, _mem_addr, addr);
      end
      respond(3, NOP, 1'b1);
      vectors++;
      if (_inst_ready_out !== 1'b1 || _mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL seq_push %0d: got rdy=%b req=%b, required rdy=1 req=0",
                 k, _inst_ready_out, _mem_req);
      end
      tick();
      addr = addr + 32'd4;
      vectors++;
      if (_inst_ready_out !== 1'b0 || _mem_req !== 1'b1 || _mem_addr !== addr) begin
        miscompares++;
        $display("FAIL seq_next %0d: got rdy=%b req=%b addr=%h, required rdy=0 req=1 addr=%h",
                 k, _inst_ready_out, _mem_req, _mem_addr, addr);
      end
    end
  endtask

  task automatic test_clear_wait();
    do_reset(1'b0);
    expect_req(32'h0, "cw_req0");
    respond(1, NOP, 1'b1);
    expect_req(32'h4, "cw_req4");
    respond(1, NOP, 1'b1);
    expect_req(32'h8, "cw_req8");
    tick();
    _clear    = 1'b1;
    _clear_pc = 32'h0000_0103;
    tick();
    _clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (_mem_req !== 1'b1 || _mem_addr !== 32'h8 || _inst_ready_out !== 1'b0) begin
        miscompares++;
        $display("FAIL cw_hold %0d: got req=%b addr=%h rdy=%b, required req=1 addr=8 rdy=0",
                 i, _mem_req, _mem_addr, _inst_ready_out);
      end
      if (i == 0) tick();
    end
    respond(1, 32'hBAD0_BAD0, 1'b0);
    vectors++;
    if (_mem_req !== 1'b0 || _inst_ready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL cw_drop: got req=%b rdy=%b, required req=0 rdy=0",
               _mem_req, _inst_ready_out);
    end
    expect_req(32'h100, "cw_redirect");
  endtask

  task automatic test_clear_same_cycle();
    do_reset(1'b0);
    expect_req(32'h0, "cs_req0");
    tick();
    _clear     = 1'b1;
    _clear_pc  = 32'h0000_0200;
    _mem_ready = 1'b1;
    _mem_data  = 32'hBAD1_BAD1;
    tick();
    _clear     = 1'b0;
    _mem_ready = 1'b0;
    vectors++;
    if (_mem_req !== 1'b0 || _inst_ready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL cs_drop: got req=%b rdy=%b, required req=0 rdy=0",
               _mem_req, _inst_ready_out);
    end
    expect_req(32'h200, "cs_redirect");
  endtask

  task automatic test_rdy_low();
    do_reset(1'b0);
    expect_req(32'h0, "rl_req0");
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      _mem_ready = (i == 2);
      _mem_data  = 32'hBAD2_BAD2;
      tick();
      vectors++;
      if (_mem_req !== 1'b1 || _mem_addr !== 32'h0 || _inst_ready_out !== 1'b0) begin
        miscompares++;
        $display("FAIL rl_freeze %0d: got req=%b addr=%h rdy=%b, required req=1 addr=0 rdy=0",
                 i, _mem_req, _mem_addr, _inst_ready_out);
      end
    end
    _mem_ready = 1'b0;
    rdy_in     = 1'b1;
    respond(2, 32'hDEAD_BEEF, 1'b1);
    vectors++;
    if (_inst_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rl_resume: got rdy=%b, required 1", _inst_ready_out);
    end
    expect_req(32'h4, "rl_next");
  endtask

  task automatic test_jal();
    logic [31:0] exp_next;
`ifdef FETCH_JAL_PREDICT_EN
    exp_next = 32'h18;
`else
    exp_next = 32'h14;
`endif
    do_reset(1'b0);
    for (int a = 0; a < 16; a += 4) begin
      expect_req(32'(a), "jal_warm");
      respond(1, NOP, 1'b1);
    end
    expect_req(32'h10, "jal_req");
    respond(1, JAL, 1'b1);
    vectors++;
    if (_inst_out !== JAL || _inst_addr_out !== 32'h10) begin
      miscompares++;
      $display("FAIL jal_push: got inst=%h addr=%h, required inst=%h addr=10",
               _inst_out, _inst_addr_out, JAL);
    end
    expect_req(exp_next, "jal_next");
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    _clear    = 1'b1;
    _clear_pc = 32'hFFFF_FFFF;
    tick();
    _clear = 1'b0;
    vectors++;
    if (_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_clear_idle: got req=%b, required 0", _mem_req);
    end
    _issue_full = 1'b0;
    expect_req(32'hFFFF_FFFC, "wrap_top");
    respond(1, NOP, 1'b1);
    expect_req(32'h0, "wrap_zero");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_backpressure();
    test_sequential();
    test_clear_wait();
    test_clear_same_cycle();
    test_rdy_low();
    test_jal();
    test_wrap();
    tick();
    tick();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending pushes, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
